// File: rtl/tex_fetch_arbiter.sv
// Round-robin fetch arbiter sharing one texture unit, with in-order response routing.
// Optional stall counter enabled by defining TEX_ARB_PERF_EN.
module tex_fetch_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int COORD_WIDTH     = 32,
    parameter int COLOR_WIDTH     = 128,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  enable_i,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    input  logic [NUM_REQ-1:0][COORD_WIDTH-1:0]   req_coord_i,
    input  logic [NUM_REQ-1:0][3:0]               req_sampler_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    output logic                                  tex_fetch_o,
    output logic [COORD_WIDTH-1:0]                tex_coord_o,
    output logic [3:0]                            tex_sampler_o,
    input  logic                                  tex_ready_i,
    input  logic [COLOR_WIDTH-1:0]                tex_color_i,
    input  logic                                  tex_valid_i,
    output logic                                  tex_ready_o,
    output logic [COLOR_WIDTH-1:0]                rsp_color_o,
    output logic [NUM_REQ-1:0]                    rsp_valid_o,
    input  logic [NUM_REQ-1:0]                    rsp_ready_i,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
    output logic                                  err_unexp_rsp_o,
    output logic [31:0]                           stall_cycles_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   lock_id_q;
    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   tag_mem [MAX_OUTSTANDING];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;

    logic            found;
    logic [IW-1:0]   scan_id;
    int              idx;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;
    logic            issue;
    logic            fifo_empty;
    logic            rsp_live;
    logic [IW-1:0]   head;
    logic            pop;

    // Search upward from the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        found   = 1'b0;
        scan_id = '0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found   = 1'b1;
                scan_id = IW'(idx);
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        if (rst_n_i) begin
            unique case (state_q)
                S_LOCK: begin
                    grant_valid = 1'b1;
                    grant_id    = lock_id_q;
                end
                S_IDLE: begin
                    if (enable_i && (cnt_q < MAX_CNT) && found) begin
                        grant_valid = 1'b1;
                        grant_id    = scan_id;
                    end
                end
                default: ;
            endcase
        end
        issue   = grant_valid && tex_ready_i;
        state_d = (grant_valid && !tex_ready_i) ? S_LOCK : S_IDLE;
    end

    always_comb begin
        req_ready_o = '0;
        if (issue) req_ready_o[grant_id] = 1'b1;
    end

    assign tex_fetch_o   = grant_valid;
    assign tex_coord_o   = grant_valid ? req_coord_i[grant_id] : '0;
    assign tex_sampler_o = grant_valid ? req_sampler_i[grant_id] : '0;

    assign fifo_empty  = (cnt_q == '0);
    assign rsp_live    = rst_n_i && !fifo_empty;
    assign head        = tag_mem[rd_q];
    assign tex_ready_o = rsp_live && rsp_ready_i[head];
    assign rsp_color_o = tex_color_i;
    assign pop         = tex_valid_i && tex_ready_o;

    always_comb begin
        rsp_valid_o = '0;
        if (tex_valid_i && rsp_live) rsp_valid_o[head] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            lock_id_q <= '0;
            rr_q      <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_valid) lock_id_q <= grant_id;
            if (issue) begin
                rr_q <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                wr_q <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            unique case ({issue, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (tex_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    // Tag storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (issue) tag_mem[wr_q] <= grant_id;
    end

    assign outstanding_o   = cnt_q;
    assign err_unexp_rsp_o = err_q;

`ifdef TEX_ARB_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
        end else if ((|req_valid_i) && !issue && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_tex_fetch_arbiter.sv
// Directed-vector bench for tex_fetch_arbiter with immediate assertions.
module tb_tex_fetch_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [3:0]        req_valid;
    logic [3:0][31:0]  req_coord;
    logic [3:0][3:0]   req_sampler;
    logic [3:0]        req_ready;
    logic              tex_fetch;
    logic [31:0]       tex_coord;
    logic [3:0]        tex_sampler;
    logic              tex_ready_in;
    logic [127:0]      tex_color;
    logic              tex_valid;
    logic              tex_ready_out;
    logic [127:0]      rsp_color;
    logic [3:0]        rsp_valid;
    logic [3:0]        rsp_ready;
    logic [3:0]        outstanding;
    logic              err_unexp;
    logic [31:0]       stall_cycles;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    tex_fetch_arbiter #(
        .NUM_REQ(4), .COORD_WIDTH(32), .COLOR_WIDTH(128), .MAX_OUTSTANDING(8)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
        .req_valid_i(req_valid), .req_coord_i(req_coord),
        .req_sampler_i(req_sampler), .req_ready_o(req_ready),
        .tex_fetch_o(tex_fetch), .tex_coord_o(tex_coord),
        .tex_sampler_o(tex_sampler), .tex_ready_i(tex_ready_in),
        .tex_color_i(tex_color), .tex_valid_i(tex_valid),
        .tex_ready_o(tex_ready_out), .rsp_color_o(rsp_color),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .outstanding_o(outstanding), .err_unexp_rsp_o(err_unexp),
        .stall_cycles_o(stall_cycles)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    int order [4] = '{0, 2, 0, 2};
    logic [3:0] exp_oh;
    logic [127:0] c1, c2, c3, c4;

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b1;
        req_valid    = '0;
        tex_ready_in = 1'b0;
        tex_color    = '0;
        tex_valid    = 1'b0;
        rsp_ready    = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_coord[i]   = 32'hC000_0000 + 32'(i);
            req_sampler[i] = 4'(i + 1);
        end
        c1 = {4{32'h1111_1111}};
        c2 = {4{32'h2222_2222}};
        c3 = {4{32'h3333_3333}};
        c4 = {4{32'h4444_4444}};
        tick();
        do_reset();

        chk("rst_outstanding", outstanding, 0);
        chk("rst_fetch", tex_fetch, 0);
        chk("rst_coord", tex_coord, 0);
        chk("rst_err", err_unexp, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_tex_ready", tex_ready_out, 0);

        // requesters 0 and 2 alternate
        req_valid    = 4'b0101;
        tex_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_oh = 4'b0001 << order[k];
            chk("rr_ready", req_ready, exp_oh);
            chk("rr_coord", tex_coord, 32'hC000_0000 + 32'(order[k]));
            chk("rr_sampler", tex_sampler, 4'(order[k] + 1));
            tick();
        end
        req_valid    = '0;
        tex_ready_in = 1'b0;
        #1;
        chk("rr_outstanding", outstanding, 4);

        // stall on requester 1 while 3 joins; enable dropped mid-lock
        req_valid = 4'b0010;
        #1;
        chk("lock_fetch0", tex_fetch, 1);
        chk("lock_coord0", tex_coord, 32'hC000_0001);
        chk("lock_ready0", req_ready, 0);
        tick();
        req_valid = 4'b1010;
        enable    = 1'b0;
        #1;
        chk("lock_coord1", tex_coord, 32'hC000_0001);
        tick();
        enable = 1'b1;
        #1;
        chk("lock_coord2", tex_coord, 32'hC000_0001);
        chk("lock_ready2", req_ready, 0);
        tex_ready_in = 1'b1;
        #1;
        chk("lock_issue1", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1000;
        #1;
        chk("after_lock_3", req_ready, 4'b1000);
        chk("after_lock_coord", tex_coord, 32'hC000_0003);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("lock_outstanding", outstanding, 6);

        // fill to 8, then check the 9th is held off
        tick();
        tick();
        chk("full_count", outstanding, 8);
        chk("full_fetch", tex_fetch, 0);
        chk("full_ready", req_ready, 0);
        tex_valid = 1'b1;
        tex_color = c1;
        #1;
        chk("full_pop_rdy", tex_ready_out, 1);
        chk("full_pop_valid", rsp_valid, 4'b0001);
        tick();
        tex_valid = 1'b0;
        #1;
        chk("resume_count", outstanding, 7);
        chk("resume_fetch", tex_fetch, 1);
        chk("resume_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("refull_count", outstanding, 8);

        // mid-operation reset
        do_reset();
        chk("midrst_count", outstanding, 0);

        // issue 3,0,1
        req_valid = 4'b1000;
        #1;
        chk("ord_issue3", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("ord_issue0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0010;
        #1;
        chk("ord_issue1", req_ready, 4'b0010);
        tick();
        req_valid    = '0;
        tex_ready_in = 1'b0;
        tex_valid    = 1'b1;
        tex_color    = c1;
        #1;
        chk("rsp1_valid", rsp_valid, 4'b1000);
        chk("rsp1_color", rsp_color, c1);
        chk("rsp1_ready", tex_ready_out, 1);
        tick();
        tex_color = c2;
        rsp_ready = 4'b1110;
        #1;
        chk("rsp2_valid", rsp_valid, 4'b0001);
        chk("rsp2_blocked", tex_ready_out, 0);
        tick();
        chk("rsp2_hold_count", outstanding, 2);
        chk("rsp2_hold_valid", rsp_valid, 4'b0001);
        rsp_ready = 4'b1111;
        #1;
        chk("rsp2_ready", tex_ready_out, 1);
        chk("rsp2_color", rsp_color, c2);
        tick();
        // pop C3 while issuing requester 2
        tex_color    = c3;
        req_valid    = 4'b0100;
        tex_ready_in = 1'b1;
        #1;
        chk("rsp3_valid", rsp_valid, 4'b0010);
        chk("both_issue", req_ready, 4'b0100);
        tick();
        req_valid    = '0;
        tex_ready_in = 1'b0;
        tex_color    = c4;
        #1;
        chk("both_count", outstanding, 1);
        chk("rsp4_valid", rsp_valid, 4'b0100);
        chk("rsp4_color", rsp_color, c4);
        tick();
        tex_valid = 1'b0;
        #1;
        chk("drain_count", outstanding, 0);

        // unexpected response
        tex_valid = 1'b1;
        tex_color = c1;
        #1;
        chk("unexp_ready", tex_ready_out, 0);
        chk("unexp_valid", rsp_valid, 0);
        chk("unexp_err_pre", err_unexp, 0);
        tick();
        tex_valid = 1'b0;
        #1;
        chk("unexp_err", err_unexp, 1);
        tick();
        chk("unexp_sticky", err_unexp, 1);
        do_reset();
        chk("unexp_cleared", err_unexp, 0);

        // stall counter
        req_valid    = 4'b0001;
        tex_ready_in = 1'b0;
        for (int k = 0; k < 5; k++) tick();
`ifdef TEX_ARB_PERF_EN
        chk("stall_count", stall_cycles, 5);
`else
        chk("stall_count", stall_cycles, 0);
`endif
        chk("stall_fetch", tex_fetch, 1);
        req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
